// File: rtl/four_way_switch_sequencer.sv
// four_way_switch_sequencer
//
// Schedule controller for a one-input, four-output link switch. A table of
// (output port, packet count) entries is loaded while idle. On run, the
// sequencer steps through the table. It routes exactly the programmed number
// of packets to each port. One dead cycle (GAP) separates entries, so the
// switch setting never changes while the switch is enabled.
//
// Ports:
//   clock            sole clock
//   reset            asynchronous, active-low reset (also clears the table)
//   config_write     table write strobe, honoured only while idle
//   config_address   table entry to write
//   config_port      output port for the entry
//   config_count     packets for the entry; 0 marks end of schedule
//   run              level: start the schedule, or keep it running
//   loop             at end of schedule: 1 wraps to entry 0, 0 halts
//   observed_req     req of the switch input link
//   observed_ack     ack of the switch input link
//   enable           switch enable (registered)
//   setting          switch setting (registered)
//   busy             high whenever not idle
//   done             one-cycle pulse at normal end of schedule
//   entry_index      current table entry
module four_way_switch_sequencer #(
  parameter int DEPTH       = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     config_write,
  input  logic [$clog2(DEPTH)-1:0] config_address,
  input  logic [1:0]               config_port,
  input  logic [COUNT_WIDTH-1:0]   config_count,
  input  logic                     run,
  input  logic                     loop,
  input  logic                     observed_req,
  input  logic                     observed_ack,
  output logic                     enable,
  output logic [1:0]               setting,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] entry_index
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GAP   = 2'd1,
    S_ROUTE = 2'd2
  } state_t;

  state_t r_state, w_state_next;

  logic [1:0]             r_port  [DEPTH];
  logic [COUNT_WIDTH-1:0] r_count [DEPTH];

  logic [IW-1:0]          r_index,   w_index_next;
  logic [COUNT_WIDTH-1:0] r_counter, w_counter_next;
  logic                   r_enable,  w_enable_next;
  logic [1:0]             r_setting, w_setting_next;
  logic                   r_done,    w_done_next;

  logic                   w_xfer;
  logic                   w_cfg_we;
  logic [IW-1:0]          w_index_plus1;
  logic [COUNT_WIDTH-1:0] w_counter_plus1;
  logic                   w_last_entry;

  assign w_xfer          = observed_req && observed_ack;
  assign w_cfg_we        = config_write && (r_state == S_IDLE);
  assign w_index_plus1   = r_index + 1'b1;
  assign w_counter_plus1 = r_counter + 1'b1;
  // The index+1 lookup wraps at DEPTH-1, but the first term masks that case.
  assign w_last_entry    = (r_index == IW'(DEPTH - 1)) ||
                           (r_count[w_index_plus1] == '0);

  // Schedule table. It is cleared by reset, so it is held in flops, not RAM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_port[i]  <= 2'd0;
        r_count[i] <= '0;
      end
    end else if (w_cfg_we) begin
      r_port[config_address]  <= config_port;
      r_count[config_address] <= config_count;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_index   <= '0;
      r_counter <= '0;
      r_enable  <= 1'b0;
      r_setting <= 2'd0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_index   <= w_index_next;
      r_counter <= w_counter_next;
      r_enable  <= w_enable_next;
      r_setting <= w_setting_next;
      r_done    <= w_done_next;
    end
  end

  // The setting is loaded on the edge that enters GAP. It is therefore already
  // valid during the dead cycle, and it is stable before enable rises.
  always_comb begin
    w_state_next   = r_state;
    w_index_next   = r_index;
    w_counter_next = r_counter;
    w_setting_next = r_setting;
    w_done_next    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A write in the same cycle as run defers the start by one cycle.
        if (run && !config_write) begin
          if (r_count[0] != '0) begin
            w_state_next   = S_GAP;
            w_index_next   = '0;
            w_counter_next = '0;
            w_setting_next = r_port[0];
          end else begin
            w_done_next = 1'b1;
          end
        end
      end
      S_GAP: begin
        w_state_next   = S_ROUTE;
        w_counter_next = '0;
      end
      S_ROUTE: begin
        if (w_xfer) begin
          if (w_counter_plus1 == r_count[r_index]) begin
            w_counter_next = '0;
            if (!w_last_entry) begin
              w_state_next   = S_GAP;
              w_index_next   = w_index_plus1;
              w_setting_next = r_port[w_index_plus1];
            end else if (loop) begin
              w_state_next   = S_GAP;
              w_index_next   = '0;
              w_setting_next = r_port[0];
            end else begin
              w_state_next = S_IDLE;
              w_index_next = '0;
              w_done_next  = 1'b1;
            end
          end else begin
            w_counter_next = w_counter_plus1;
          end
        end else if (!run) begin
          // A transfer takes precedence over abort. The abort is re-evaluated
          // on the next cycle.
          w_state_next   = S_IDLE;
          w_index_next   = '0;
          w_counter_next = '0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign w_enable_next = (w_state_next == S_ROUTE);

  assign enable      = r_enable;
  assign setting     = r_setting;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign entry_index = r_index;

endmodule

// File: doc/four_way_switch_sequencer.md
# four_way_switch_sequencer

Programmable schedule controller that drives the `enable` and `setting` inputs of a one-input, four-output link switch. A small table of (output port, packet count) entries is loaded while the sequencer is idle. On `run`, the sequencer steps through the table and routes exactly the programmed number of packets to each port. It inserts one dead cycle between entries so the switch never changes setting while enabled. It sits beside the switch in the interconnect and counts completed handshakes on the switch's input link.

## Interface
- `DEPTH`, 8: number of schedule entries, power of two, ≥ 2.
- `COUNT_WIDTH`, 8: width of the per-entry packet count.

- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low reset.
- `config_write`  in  1  write strobe for a table entry.
- `config_address`  in  $clog2(DEPTH)  entry to write.
- `config_port`  in  2  output port for the entry.
- `config_count`  in  COUNT_WIDTH  packets to route for the entry; 0 marks end of schedule.
- `run`  in  1  level: start the schedule, or keep it running.
- `loop`  in  1  at end of schedule: 1 wraps to entry 0, 0 halts.
- `observed_req`  in  1  req of the switch input link.
- `observed_ack`  in  1  ack of the switch input link.
- `enable`  out  1  switch enable, registered.
- `setting`  out  2  switch setting, registered.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at normal end of schedule.
- `entry_index`  out  $clog2(DEPTH)  current entry.

## Operation
- A transfer is any cycle with `observed_req && observed_ack`.
- Reset: state IDLE. `enable`=0, `setting`=0, `busy`=0, `done`=0, `entry_index`=0, packet counter=0, all table entries (port 0, count 0).
- States:
  - IDLE: `enable`=0. `config_write` writes `table[config_address]`.
    - If `run`=1 and `config_write`=0, the sequencer checks entry 0.
    - Entry 0 count ≠ 0: go to GAP with `entry_index`=0.
    - Entry 0 count = 0: pulse `done` and stay in IDLE.
    - `config_write` has priority over `run`; start is deferred to the next cycle.
  - GAP (exactly 1 cycle): `enable`=0. `setting` loads `table[entry_index].port`. Counter clears to 0. Next state is ROUTE.
  - ROUTE: `enable`=1 and `setting` is held. Each transfer increments the counter.
    - The transfer that makes counter+1 equal the entry count ends the entry.
    - End of schedule is reached when `entry_index`=DEPTH-1 or the count of `table[entry_index+1]` is 0.
    - Entry ends, not end of schedule: go to GAP with `entry_index`+1.
    - End of schedule, `loop`=1: go to GAP with `entry_index`=0.
    - End of schedule, `loop`=0: go to IDLE, pulse `done`, set `entry_index`=0.
    - Abort: `run`=0 in a ROUTE cycle with no transfer sends the sequencer to IDLE with `entry_index`=0, counter=0, and no `done`.
    - A transfer in the same cycle as `run`=0 is counted, and the abort is evaluated on the next cycle.
- `config_write` outside IDLE is ignored, and the table is unchanged.
- Counter and index arithmetic are unsigned. The index wraps only through the `loop` path, never by overflow.
- Deasserting `enable` forces the switch's input ack to 0 combinationally. No transfer can therefore occur in GAP or IDLE, and any observed req/ack there is ignored.

## Timing
- `run` sampled high at edge N → GAP at N+1 (`busy`=1, `setting` valid, `enable`=0) → `enable`=1 from N+2.
- The last transfer of an entry at cycle T gives `enable`=0 at T+1 (GAP or IDLE). `enable` is 1 again at T+2 with the new `setting`.
- `setting` changes only in GAP/IDLE transitions and never in a cycle where `enable`=1.
- `done` is high for exactly the cycle in which the state is first IDLE after a normal end.
- Throughput: an entry of count C with back-to-back transfers occupies C+1 cycles (C in ROUTE plus 1 in GAP).
- Reset asserted mid-ROUTE: all outputs go to reset values asynchronously and the table is cleared.

## Test plan
- Reset values: assert `reset`=0 mid-ROUTE → `enable`=0, `setting`=0, `busy`=0, `entry_index`=0 immediately; after release with `run`=1, entry 0 count is 0 → `done` pulse, IDLE.
- Single entry: table[0]=(port 2, count 3), table[1] count 0, `loop`=0, transfer every cycle → `enable` high exactly 3 cycles with `setting`=2, then `done` pulse, `busy`=0.
- Multi-entry with stalls: entries (1,2),(3,1),(0,4), ack high every other cycle → per-port transfer counts exactly 2/1/4; one `enable`=0 cycle between entries; `setting` stable whenever `enable`=1.
- Loop and full table: DEPTH entries all count 1, `loop`=1 → `entry_index` runs 0..7 then back to 0, no `done`; clear `loop` → `done` after entry 7.
- Abort: `run`=0 during entry (2,5) after 2 transfers, req low → IDLE next cycle, no `done`; with a transfer in the `run`=0 cycle → that transfer is counted (3), then IDLE.
- Config gating: `config_write` during ROUTE → table unchanged (read back via a later run); `config_write` and `run` in the same IDLE cycle → write lands, GAP begins one cycle later.
